// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: load/store request on a req/ack bus,
// pipeline stall while outstanding, aligned + extended load result, timeout abort.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ERR_CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_acc_valid,
    input  logic                 i_acc_read,
    input  logic                 i_acc_write,
    input  logic [1:0]           i_acc_size,
    input  logic                 i_acc_unsigned,
    input  logic [31:0]          i_acc_addr,
    input  logic [31:0]          i_acc_wdata,
    output logic                 o_dmem_req,
    output logic                 o_dmem_we,
    output logic [31:0]          o_dmem_addr,
    output logic [3:0]           o_dmem_be,
    output logic [31:0]          o_dmem_wdata,
    input  logic                 i_dmem_ack,
    input  logic [31:0]          i_dmem_rdata,
    output logic [31:0]          o_load_data,
    output logic                 o_mem_stall,
    output logic                 o_misalign,
    output logic                 o_bus_error,
    output logic [ERR_CNT_W-1:0] o_err_count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [1:0]           r_size;
    logic                 r_uns;
    logic [1:0]           r_alo;
    logic                 r_rd;
    logic [ERR_CNT_W-1:0] r_err;

    logic        w_access, w_bad, w_start, w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_sh_b, w_sh_h, w_ld;

    assign w_access = i_acc_valid & (i_acc_read | i_acc_write);

    always_comb begin
        case (i_acc_size)
            2'b00:   w_bad = 1'b0;
            2'b01:   w_bad = i_acc_addr[0];
            2'b10:   w_bad = |i_acc_addr[1:0];
            default: w_bad = 1'b1;
        endcase
    end

    assign o_misalign  = (r_state == S_IDLE) & w_access & w_bad;
    assign w_start     = (r_state == S_IDLE) & w_access & ~w_bad;
    assign o_mem_stall = w_start | (r_state == S_BUSY);
    assign w_timeout   = (r_state == S_BUSY) & ~i_dmem_ack & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Sub-word stores replicate the data across all lanes; byte enables pick the lane.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_acc_wdata;
        case (i_acc_size)
            2'b00: begin
                w_be    = 4'b0001 << i_acc_addr[1:0];
                w_wdata = {4{i_acc_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << i_acc_addr[1:0];
                w_wdata = {2{i_acc_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_sh_b = i_dmem_rdata >> {r_alo, 3'b000};
    assign w_sh_h = i_dmem_rdata >> {r_alo[1], 4'b0000};

    always_comb begin
        case (r_size)
            2'b00:   w_ld = {{24{~r_uns & w_sh_b[7]}}, w_sh_b[7:0]};
            2'b01:   w_ld = {{16{~r_uns & w_sh_h[15]}}, w_sh_h[15:0]};
            default: w_ld = i_dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_size       <= '0;
            r_uns        <= 1'b0;
            r_alo        <= '0;
            r_rd         <= 1'b0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_be    <= '0;
            o_dmem_wdata <= '0;
            o_load_data  <= '0;
            o_bus_error  <= 1'b0;
        end else begin
            o_bus_error <= 1'b0;
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_size       <= i_acc_size;
                    r_uns        <= i_acc_unsigned;
                    r_alo        <= i_acc_addr[1:0];
                    r_rd         <= i_acc_read;
                    r_cnt        <= '0;
                    o_dmem_req   <= 1'b1;
                    o_dmem_we    <= ~i_acc_read;
                    o_dmem_addr  <= {i_acc_addr[31:2], 2'b00};
                    o_dmem_be    <= w_be;
                    o_dmem_wdata <= w_wdata;
                    r_state      <= S_BUSY;
                end
                S_BUSY: begin
                    if (i_dmem_ack) begin
                        o_dmem_req <= 1'b0;
                        if (r_rd) o_load_data <= w_ld;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        o_dmem_req  <= 1'b0;
                        o_bus_error <= 1'b1;
                        if (r_rd) o_load_data <= '0;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Misalign lives in IDLE and timeout in BUSY, so at most one event per cycle.
    always_ff @(posedge clk) begin
        if (reset)
            r_err <= '0;
        else if ((o_misalign | w_timeout) && (r_err != {ERR_CNT_W{1'b1}}))
            r_err <= r_err + 1'b1;
    end

    assign o_err_count = r_err;
endmodule
